// File: rtl/can_rx_pkg.sv
// Shared types and constants for the CAN receive ring writer.
// Holds the FSM states, the per-frame word offsets and the header word layout.
package can_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W0,
    ST_W1,
    ST_W2,
    ST_W3
  } state_t;

  localparam logic [1:0] WORD_HDR = 2'd0;
  localparam logic [1:0] WORD_TS  = 2'd1;
  localparam logic [1:0] WORD_D0  = 2'd2;
  localparam logic [1:0] WORD_D1  = 2'd3;

  localparam int IDE_BIT = 31;
  localparam int RTR_BIT = 30;

  // Header word: flags on top, bit 29 reserved as zero, identifier right-aligned.
  function automatic logic [31:0] hdr_word(input logic ide, input logic rtr,
                                           input logic [28:0] id);
    logic [31:0] w;
    w          = '0;
    w[IDE_BIT] = ide;
    w[RTR_BIT] = rtr;
    w[28:0]    = id;
    return w;
  endfunction

endpackage

// File: rtl/can_rx_frame_writer.sv
// Writes received CAN frames as four-word records into a RAM ring buffer and
// publishes a committed write index plus a not-empty interrupt for software.
module can_rx_frame_writer
  import can_rx_pkg::*;
#(
  parameter logic [12:0] BASE_WORD    = 13'h1F00,
  parameter int          DEPTH_FRAMES = 64,
  parameter int          PTR_W        = $clog2(DEPTH_FRAMES) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_valid,
  output logic             frame_ready,
  input  logic [28:0]      frame_id,
  input  logic             frame_ide,
  input  logic             frame_rtr,
  input  logic [3:0]       frame_dlc,
  input  logic [63:0]      frame_data,
  input  logic [PTR_W-1:0] rd_idx,
  output logic [PTR_W-1:0] wr_idx,
  output logic [12:0]      avm_address,
  output logic [3:0]       avm_byteenable,
  output logic             avm_chipselect,
  output logic             avm_write,
  output logic [31:0]      avm_writedata,
  output logic             avm_clken,
  output logic [15:0]      overflow_cnt,
  output logic             irq
);

  state_t state, nstate;

  logic [15:0] ts;
  logic [28:0] id_q;
  logic        ide_q, rtr_q;
  logic [3:0]  dlc_q;
  logic [63:0] data_q;
  logic [15:0] ts_q;

  logic [PTR_W-1:0] fill;
  logic             full, accept, wr_cyc;
  logic [1:0]       word_sel;
  logic [12:0]      slot_base;

  // Unsigned modular distance; anything at or past capacity (including a
  // corrupt read index) is treated as full so the ring is never overrun.
  assign fill      = wr_idx - rd_idx;
  assign full      = fill >= PTR_W'(DEPTH_FRAMES);
  assign accept    = frame_valid & frame_ready;
  assign slot_base = 13'(wr_idx[PTR_W-2:0]) << 2;
  assign avm_clken = 1'b1;

  always_comb begin
    nstate      = state;
    frame_ready = 1'b0;
    wr_cyc      = 1'b0;
    word_sel    = WORD_D1;  // idle keeps the last written word on the bus
    case (state)
      ST_IDLE: begin
        frame_ready = 1'b1;
        if (frame_valid && !full) nstate = ST_W0;
      end
      ST_W0: begin wr_cyc = 1'b1; word_sel = WORD_HDR; nstate = ST_W1;   end
      ST_W1: begin wr_cyc = 1'b1; word_sel = WORD_TS;  nstate = ST_W2;   end
      ST_W2: begin wr_cyc = 1'b1; word_sel = WORD_D0;  nstate = ST_W3;   end
      ST_W3: begin wr_cyc = 1'b1; word_sel = WORD_D1;  nstate = ST_IDLE; end
      default: nstate = ST_IDLE;
    endcase

    avm_chipselect = wr_cyc;
    avm_write      = wr_cyc;
    avm_byteenable = wr_cyc ? 4'hF : 4'h0;
    avm_address    = wr_cyc ? (BASE_WORD + slot_base + 13'(word_sel)) : 13'h0;

    case (word_sel)
      WORD_HDR: avm_writedata = hdr_word(ide_q, rtr_q, id_q);
      WORD_TS:  avm_writedata = {ts_q, 12'h000, dlc_q};
      WORD_D0:  avm_writedata = data_q[31:0];
      default:  avm_writedata = data_q[63:32];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      ts           <= '0;
      id_q         <= '0;
      ide_q        <= 1'b0;
      rtr_q        <= 1'b0;
      dlc_q        <= '0;
      data_q       <= '0;
      ts_q         <= '0;
      wr_idx       <= '0;
      overflow_cnt <= '0;
      irq          <= 1'b0;
    end else begin
      state <= nstate;
      ts    <= ts + 16'd1;
      irq   <= (wr_idx != rd_idx);
      if (accept && full && overflow_cnt != 16'hFFFF)
        overflow_cnt <= overflow_cnt + 16'd1;
      if (accept && !full) begin
        id_q   <= frame_id;
        ide_q  <= frame_ide;
        rtr_q  <= frame_rtr;
        dlc_q  <= frame_dlc;
        data_q <= frame_data;
        ts_q   <= ts;
      end
      // Commit only after the last word lands so software never reads a torn slot.
      if (state == ST_W3) wr_idx <= wr_idx + PTR_W'(1);
    end
  end

endmodule

// File: tb/tb_can_rx_frame_writer.sv
// Directed bench for can_rx_frame_writer: frame layout, ring full/drop,
// index wrap, back-to-back throughput and reset in the middle of a frame.
module tb_can_rx_frame_writer;

  logic        clk, reset;
  logic        frame_valid, frame_ready;
  logic [28:0] frame_id;
  logic        frame_ide, frame_rtr;
  logic [3:0]  frame_dlc;
  logic [63:0] frame_data;
  logic [6:0]  rd_idx, wr_idx;
  logic [12:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect, avm_write, avm_clken, irq;
  logic [31:0] avm_writedata;
  logic [15:0] overflow_cnt;

  can_rx_frame_writer dut (
    .clk(clk), .reset(reset),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_id(frame_id), .frame_ide(frame_ide), .frame_rtr(frame_rtr),
    .frame_dlc(frame_dlc), .frame_data(frame_data),
    .rd_idx(rd_idx), .wr_idx(wr_idx),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_clken(avm_clken),
    .overflow_cnt(overflow_cnt), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timestamp: cycles since reset release.
  logic [15:0] cyc;
  always @(posedge clk or posedge reset)
    if (reset) cyc <= '0;
    else       cyc <= cyc + 16'd1;

  typedef struct {
    logic [28:0] id;
    logic        ide, rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [31:0] w0, w2, w3;
  } vec_t;

  vec_t tbl[5];
  int checks = 0;
  int errors = 0;
  logic [6:0] exp_wr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_ready"}, frame_ready, 1);
    chk({tag, "_clken"}, avm_clken, 1);
    chk({tag, "_wridx"}, wr_idx, 0);
    chk({tag, "_irq"}, irq, 0);
    chk({tag, "_ovf"}, overflow_cnt, 0);
    chk({tag, "_write"}, avm_write, 0);
    chk({tag, "_cs"}, avm_chipselect, 0);
    chk({tag, "_be"}, avm_byteenable, 0);
    chk({tag, "_wdata"}, avm_writedata, 0);
    chk({tag, "_addr"}, avm_address, 0);
  endtask

  // Presents one frame, lets it be accepted, and optionally checks the four
  // write cycles plus the commit cycle.
  task automatic send(input vec_t v, input bit chk_en, input bit ts_model,
                      input logic [31:0] e1_fixed, input logic [12:0] ebase);
    logic [31:0] ew[4];
    frame_id = v.id; frame_ide = v.ide; frame_rtr = v.rtr;
    frame_dlc = v.dlc; frame_data = v.data; frame_valid = 1'b1;
    if (chk_en) chk("acc_ready", frame_ready, 1);
    ew[0] = v.w0;
    ew[1] = ts_model ? {cyc, 12'h000, v.dlc} : e1_fixed;
    ew[2] = v.w2;
    ew[3] = v.w3;
    tick();
    frame_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (chk_en) begin
        chk($sformatf("w%0d_write", k), {avm_write, avm_chipselect, avm_byteenable}, 6'h3F);
        chk($sformatf("w%0d_addr", k), avm_address, ebase + 13'(k));
        chk($sformatf("w%0d_data", k), avm_writedata, ew[k]);
        chk($sformatf("w%0d_ready", k), frame_ready, 0);
      end
      tick();
    end
    exp_wr = exp_wr + 7'd1;
    if (chk_en) begin
      chk("commit_wridx", wr_idx, exp_wr);
      chk("commit_ready", frame_ready, 1);
      chk("commit_write", avm_write, 0);
      chk("hold_wdata", avm_writedata, v.w3);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{29'h123, 1'b0, 1'b0, 4'd8, 64'h8877665544332211,
               32'h00000123, 32'h44332211, 32'h88776655};
    tbl[1] = '{29'h1ABCDEF0, 1'b1, 1'b0, 4'd4, 64'h00000000DEADBEEF,
               32'h9ABCDEF0, 32'hDEADBEEF, 32'h00000000};
    tbl[2] = '{29'h7FF, 1'b0, 1'b1, 4'd0, 64'h0,
               32'h400007FF, 32'h00000000, 32'h00000000};
    tbl[3] = '{29'h1FFFFFFF, 1'b1, 1'b1, 4'hF, 64'hFFFFFFFFFFFFFFFF,
               32'hDFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[4] = '{29'h0, 1'b0, 1'b0, 4'd1, 64'h0123456789ABCDEF,
               32'h00000000, 32'h89ABCDEF, 32'h01234567};

    reset = 1'b1; frame_valid = 1'b0; frame_id = '0; frame_ide = 1'b0;
    frame_rtr = 1'b0; frame_dlc = '0; frame_data = '0; rd_idx = '0; exp_wr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_reset("rst");
    reset = 1'b0;  // this cycle has timestamp 0

    // First frame accepted while the timestamp reads 16'h0010.
    repeat (16) tick();
    send(tbl[0], 1'b1, 1'b0, 32'h00100008, 13'h1F00);
    chk("irq_lag", irq, 0);
    tick();
    chk("irq_set", irq, 1);

    for (int i = 1; i < 5; i++)
      send(tbl[i], 1'b1, 1'b1, 32'h0, 13'h1F00 + 13'({exp_wr[5:0], 2'b00}));

    // Fill the ring with rd_idx held at 0.
    while (exp_wr != 7'h40) send(tbl[exp_wr % 5], 1'b0, 1'b0, 32'h0, 13'h0);
    chk("full_wridx", wr_idx, 7'h40);
    chk("full_irq", irq, 1);

    // 65th frame is dropped.
    frame_id = tbl[1].id; frame_valid = 1'b1;
    chk("drop_ready", frame_ready, 1);
    tick();
    frame_valid = 1'b0;
    chk("drop_write", avm_write, 0);
    chk("drop_ready2", frame_ready, 1);
    chk("drop_ovf", overflow_cnt, 1);
    chk("drop_wridx", wr_idx, 7'h40);
    tick();
    chk("drop_write2", avm_write, 0);

    rd_idx = 7'd1;
    send(tbl[2], 1'b1, 1'b1, 32'h0, 13'h1F00);
    chk("after_drop_wridx", wr_idx, 7'h41);
    chk("after_drop_ovf", overflow_cnt, 1);

    // Drain as we go up to index 7F, then wrap through slot 63.
    while (exp_wr != 7'h7F) begin
      rd_idx = exp_wr;
      send(tbl[exp_wr % 5], 1'b0, 1'b0, 32'h0, 13'h0);
    end
    rd_idx = 7'h7F;
    tick();
    send(tbl[4], 1'b1, 1'b1, 32'h0, 13'h1FFC);
    chk("wrap_wridx", wr_idx, 7'h00);
    tick();
    chk("wrap_irq", irq, 1);

    // Back-to-back frames with valid held high.
    reset = 1'b1;
    tick();
    chk_idle_reset("rst2");
    reset = 1'b0; rd_idx = '0; exp_wr = '0;
    frame_id = tbl[0].id; frame_data = tbl[0].data; frame_dlc = tbl[0].dlc;
    frame_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("b2b_ready%0d", i), frame_ready, (i % 5) == 0);
      chk($sformatf("b2b_write%0d", i), avm_write, (i % 5) != 0);
      tick();
      if (i == 10) frame_valid = 1'b0;
    end
    chk("b2b_wridx", wr_idx, 7'd3);
    chk("b2b_ready_end", frame_ready, 1);

    // Reset while writing word 2 of slot 3.
    frame_id = tbl[4].id; frame_data = tbl[4].data; frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    tick();
    tick();
    chk("mid_w2_addr", avm_address, 13'h1F0E);
    chk("mid_w2_write", avm_write, 1);
    reset = 1'b1;
    #1;
    chk_idle_reset("midrst");
    tick();
    tick();
    chk("midrst_nowrite", avm_write, 0);
    chk("midrst_wridx", wr_idx, 0);
    reset = 1'b0; exp_wr = '0;
    tick();
    send(tbl[1], 1'b1, 1'b1, 32'h0, 13'h1F00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_rx_frame_writer.md
Name: can_rx_frame_writer

Overview:
- Avalon-MM write-only master that sits directly upstream of the Nios on-chip RAM slave (13-bit word address, 32-bit data, byteenable, chipselect, write, clken).
- Takes received CAN frames from the CAN controller over a valid/ready handshake.
- Serialises each frame into four 32-bit words inside a ring buffer in the RAM.
- Exports a write index and an IRQ so Nios software can drain the ring. Software returns its read index on `rd_idx`.

Parameters:
- BASE_WORD, 13'h1F00, first RAM word address of the ring. Constraint: BASE_WORD + 4*DEPTH_FRAMES <= 8192.
- DEPTH_FRAMES, 64, ring capacity in frames; must be a power of 2, range 2..1024.
- PTR_W, log2(DEPTH_FRAMES)+1, index width; the extra MSB is the wrap bit.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_valid  in  1  CAN controller has a frame
- frame_ready  out  1  block accepts the frame this cycle
- frame_id  in  29  identifier; 11-bit IDs are right-aligned
- frame_ide  in  1  extended-ID flag
- frame_rtr  in  1  remote-frame flag
- frame_dlc  in  4  data length code
- frame_data  in  64  payload; byte0 = [7:0]
- rd_idx  in  PTR_W  software read index; quasi-static, same clock domain
- wr_idx  out  PTR_W  committed write index
- avm_address  out  13  RAM word address
- avm_byteenable  out  4  byte enables
- avm_chipselect  out  1  RAM select
- avm_write  out  1  RAM write strobe
- avm_writedata  out  32  RAM write data
- avm_clken  out  1  RAM clock enable
- overflow_cnt  out  16  frames dropped because the ring was full; saturating
- irq  out  1  level interrupt, high while the ring is not empty

Behaviour:
- Reset values: all outputs 0 except `frame_ready` = 1 and `avm_clken` = 1. Internal state: FSM = IDLE, timestamp = 0.
- Timestamp: 16-bit free-running counter, +1 every clk, wraps at 16'hFFFF -> 0.
- FSM states: IDLE, W0, W1, W2, W3.
  - `frame_ready` = 1 only in IDLE.
  - Accept = `frame_valid` & `frame_ready`.
- On accept, compute fill = (`wr_idx` - `rd_idx`) mod 2^PTR_W.
- Drop path (fill >= DEPTH_FRAMES, including a corrupt `rd_idx`):
  - No RAM write.
  - `overflow_cnt` += 1, saturating at 16'hFFFF.
  - FSM stays in IDLE; the next frame can be accepted on the following cycle.
- Store path (fill < DEPTH_FRAMES):
  - Capture id, ide, rtr, dlc, data and the current timestamp into holding registers.
  - FSM goes to W0.
- Word layout:
  - slot = `wr_idx`[PTR_W-2:0].
  - Address in state Wk = BASE_WORD + slot*4 + k.
  - W0 = {ide, rtr, 1'b0, id[28:0]}
  - W1 = {timestamp[15:0], 12'h000, dlc}
  - W2 = data[31:0]
  - W3 = data[63:32]
- RAM write cycles: in W0..W3, `avm_chipselect` = `avm_write` = 1 and `avm_byteenable` = 4'hF. Otherwise those three are 0 and `avm_writedata` holds its last value. The slave has no waitrequest, so each write completes in one cycle.
- Transitions: W0 -> W1 -> W2 -> W3 -> IDLE unconditionally.
- Commit: leaving W3, `wr_idx` += 1 mod 2^PTR_W. Software therefore never sees a partially written slot.
- Timing: accept at cycle N; writes at N+1..N+4; new `wr_idx` visible at N+5; `frame_ready` high again at N+5. Maximum throughput is 1 frame per 5 clk.
- `dlc` > 8 is stored verbatim and all four words are still written; no truncation or checking.
- `irq`: registered (`wr_idx` != `rd_idx`), so it lags an index change by 1 clk.
- Reset mid-frame: the FSM aborts and `wr_idx` returns to 0. Already-written words are left in RAM but never committed. Software must reset its own `rd_idx` to 0 as well.
- `rd_idx` changing in the same cycle as an accept: the value sampled in that cycle is used.

Decomposition:
- Package `can_rx_pkg`:
  - FSM state enum.
  - Word-offset constants WORD_HDR=0, WORD_TS=1, WORD_D0=2, WORD_D1=3.
  - Header bit positions IDE_BIT=31, RTR_BIT=30.
  - Function for the frame-header word.
- No sub-module; a single flat module is natural. The timestamp counter is inline.

Test Plan:
- Reset -> `frame_ready`=1, `avm_clken`=1, `wr_idx`=0, `irq`=0, `overflow_cnt`=0, `avm_write`=0.
- One frame (id=29'h123, ide=0, rtr=0, dlc=8, data=64'h8877665544332211) accepted at timestamp 16'h0010 ->
  - cycles N+1..N+4 write: addr 13'h1F00 = 32'h00000123; 13'h1F01 = 32'h00100008; 13'h1F02 = 32'h44332211; 13'h1F03 = 32'h88776655.
  - `wr_idx`=1 at N+5; `irq`=1 at N+6.
- Ring full: 64 frames with `rd_idx`=0 -> `wr_idx`=7'h40; a 65th frame is accepted with no write and `overflow_cnt`=1. Then set `rd_idx`=1 -> the next frame is written to 13'h1F00..13'h1F03 (slot 0) and `wr_idx`=7'h41.
- Wrap: `rd_idx`=`wr_idx`=7'h7F, send 1 frame -> writes at 13'h1FFC..13'h1FFF; `wr_idx`=7'h00; `irq`=1.
- Back-to-back: `frame_valid` held high for 3 frames -> `frame_ready` pulses every 5th cycle, 12 consecutive write cycles with no gaps beyond the IDLE cycles, `wr_idx`=3.
- Reset asserted during W2 -> outputs return to reset values immediately, `wr_idx`=0, no further writes; after release the next frame writes to 13'h1F00.
